// File: rtl/muldiv_pkg.sv
// Shared types, operator codes and operator decode for the iterative multiply/divide unit.
// The operator codes mirror the ALU operator numbering used by the execute stage.
package muldiv_pkg;

    localparam int ALU_OPERATOR_MUL   = 20;
    localparam int ALU_OPERATOR_MULH  = 21;
    localparam int ALU_OPERATOR_MULU  = 22;
    localparam int ALU_OPERATOR_MULHU = 23;
    localparam int ALU_OPERATOR_DIV   = 24;
    localparam int ALU_OPERATOR_DIVU  = 25;
    localparam int ALU_OPERATOR_REM   = 26;
    localparam int ALU_OPERATOR_REMU  = 27;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [2:0] {
        MUL_LO, MUL_HI_S, MUL_HI_U, DIV_S, DIV_U, REM_S, REM_U, ILLEGAL
    } op_class_t;

    function automatic op_class_t decode_op(input logic [31:0] op);
        op_class_t c;
        case (op)
            ALU_OPERATOR_MUL, ALU_OPERATOR_MULU: c = MUL_LO;
            ALU_OPERATOR_MULH:                   c = MUL_HI_S;
            ALU_OPERATOR_MULHU:                  c = MUL_HI_U;
            ALU_OPERATOR_DIV:                    c = DIV_S;
            ALU_OPERATOR_DIVU:                   c = DIV_U;
            ALU_OPERATOR_REM:                    c = REM_S;
            ALU_OPERATOR_REMU:                   c = REM_U;
            default:                             c = ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/muldiv_special_detect.sv
// Flags requests whose result is known without iterating: divide by zero,
// signed divide overflow and unsupported operators.
module muldiv_special_detect
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_class_t       op_class_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    output logic            is_special_o,
    output logic [XLEN-1:0] special_result_o
);

    logic div_zero;
    logic div_ovf;

    assign div_zero = (operand2_i == '0);
    assign div_ovf  = (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand2_i == '1);

    always_comb begin
        is_special_o     = 1'b0;
        special_result_o = '0;
        case (op_class_i)
            DIV_S: begin
                if (div_zero) begin
                    is_special_o     = 1'b1;
                    special_result_o = '1;
                end else if (div_ovf) begin
                    is_special_o     = 1'b1;
                    special_result_o = operand1_i;
                end
            end
            DIV_U: begin
                if (div_zero) begin
                    is_special_o     = 1'b1;
                    special_result_o = '1;
                end
            end
            REM_S: begin
                if (div_zero) begin
                    is_special_o     = 1'b1;
                    special_result_o = operand1_i;
                end else if (div_ovf) begin
                    is_special_o     = 1'b1;
                    special_result_o = '0;
                end
            end
            REM_U: begin
                if (div_zero) begin
                    is_special_o     = 1'b1;
                    special_result_o = operand1_i;
                end
            end
            ILLEGAL: is_special_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// sign handled as magnitudes plus a final negation on the last iteration edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] operator,
    input  logic [XLEN-1:0]     operand1,
    input  logic [XLEN-1:0]     operand2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                result_is_zero,
    output logic                out_illegal
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int AW = 2 * XLEN + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    op_class_t       class_q, class_d;
    logic            spec_q, spec_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    op_class_t       in_class;
    logic            in_special;
    logic [XLEN-1:0] in_special_res;
    logic            s1, s2, signed_op;
    logic [XLEN-1:0] mag1, mag2;

    assign in_class  = decode_op(32'(operator));
    assign s1        = operand1[XLEN-1];
    assign s2        = operand2[XLEN-1];
    assign signed_op = (in_class == MUL_HI_S) || (in_class == DIV_S) || (in_class == REM_S);
    assign mag1      = (signed_op && s1) ? -operand1 : operand1;
    assign mag2      = (signed_op && s2) ? -operand2 : operand2;

    muldiv_special_detect #(.XLEN(XLEN)) u_special (
        .op_class_i       (in_class),
        .operand1_i       (operand1),
        .operand2_i       (operand2),
        .is_special_o     (in_special),
        .special_result_o (in_special_res)
    );

    // acc holds {high/remainder, low/quotient}; opnd_q is the multiplicand or divisor,
    // or the precomputed answer when the request took the special path.
    logic            is_div_q;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [AW-1:0]   div_shift, step;

    assign is_div_q = (class_q == DIV_S) || (class_q == DIV_U) ||
                      (class_q == REM_S) || (class_q == REM_U);

    always_comb begin
        mul_sum   = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q << 1;
        div_trial = div_shift[AW-1:XLEN] - {1'b0, opnd_q};
        if (!is_div_q)
            step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        else if (!div_trial[XLEN])
            step = {div_trial, div_shift[XLEN-1:1], 1'b1};
        else
            step = div_shift;
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   lo, hi, fixed, final_res;

    always_comb begin
        lo       = step[XLEN-1:0];
        hi       = step[2*XLEN-1:XLEN];
        prod_fix = neg_q ? -step[2*XLEN-1:0] : step[2*XLEN-1:0];
        case (class_q)
            MUL_LO:       fixed = lo;
            MUL_HI_S:     fixed = prod_fix[2*XLEN-1:XLEN];
            MUL_HI_U:     fixed = hi;
            DIV_S, DIV_U: fixed = neg_q ? -lo : lo;
            REM_S, REM_U: fixed = neg_q ? -hi : hi;
            default:      fixed = '0;
        endcase
        final_res = spec_q ? opnd_q : fixed;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        class_d   = class_q;
        spec_d    = spec_q;
        neg_d     = neg_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = CALC;
                        class_d = in_class;
                        spec_d  = in_special;
                        // Special cases take a single pass through CALC so all requests
                        // see the same accept-to-valid structure.
                        cnt_d   = in_special ? CW'(1) : CW'(XLEN);
                        acc_d   = {{(XLEN+1){1'b0}}, mag1};
                        opnd_d  = in_special ? in_special_res : mag2;
                        case (in_class)
                            MUL_HI_S, DIV_S: neg_d = s1 ^ s2;
                            REM_S:           neg_d = s1;
                            default:         neg_d = 1'b0;
                        endcase
                    end
                end
                CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    acc_d = step;
                    if (cnt_q == CW'(1)) begin
                        state_d   = DONE;
                        result_d  = final_res;
                        zero_d    = (final_res == '0);
                        illegal_d = (class_q == ILLEGAL);
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            class_q   <= MUL_LO;
            spec_q    <= 1'b0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            class_q   <= class_d;
            spec_q    <= spec_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign result         = result_q;
    assign result_is_zero = zero_q;
    assign out_illegal    = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int OPW  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OPW-1:0]  operator = '0;
    logic [XLEN-1:0] operand1 = '0;
    logic [XLEN-1:0] operand2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            result_is_zero;
    logic            out_illegal;

    muldiv_unit #(.XLEN(XLEN), .OP_WIDTH(OPW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .operator       (operator),
        .operand1       (operand1),
        .operand2       (operand2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .result_is_zero (result_is_zero),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] res;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    int   txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        sp = sa * sb;
        e.op = op; e.ill = 1'b0; e.res = '0;
        case (int'(op))
            ALU_OPERATOR_MUL, ALU_OPERATOR_MULU: e.res = up[31:0];
            ALU_OPERATOR_MULH:  e.res = sp[63:32];
            ALU_OPERATOR_MULHU: e.res = up[63:32];
            ALU_OPERATOR_DIV: begin
                if (b == 0) e.res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
                else e.res = 32'(sa / sb);
            end
            ALU_OPERATOR_REM: begin
                if (b == 0) e.res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'h0;
                else e.res = 32'(sa % sb);
            end
            ALU_OPERATOR_DIVU: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_OPERATOR_REMU: e.res = (b == 0) ? a : a % b;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // out_ready changes well after the edge so the monitor's negedge sample
    // matches what the DUT sees at the following edge.
    always @(posedge clk) begin
        #3;
        if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = (ready_mode == 1);
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("result_is_zero", result_is_zero, mon_e.res == 0);
                check("out_illegal", out_illegal, mon_e.ill);
                txn++;
                $display("TXN %0d op=%0d result=0x%08h zero=%0b illegal=%0b",
                         txn, mon_e.op, result, result_is_zero, out_illegal);
            end
        end
    end

    // All stimulus steps run at posedge+1.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1; operator = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        operator = 5'($urandom); operand1 = $urandom; operand2 = $urandom;
        sb_q.push_back(model(op, a, b));
        ok = 1'b1;
    endtask

    task automatic run_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int exp_lat);
        bit ok;
        bit busy_ok = 1'b1;
        int lat = 0;
        issue(op, a, b, ok);
        if (!ok) return;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check("latency", lat, exp_lat);
        check("in_ready_busy", busy_ok, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [4:0]  codes [10];
        logic [4:0]  op;
        logic [31:0] a, b, ex;
        bit          ok, seen;
        int          n;

        codes = '{5'(ALU_OPERATOR_MUL), 5'(ALU_OPERATOR_MULH), 5'(ALU_OPERATOR_MULU),
                  5'(ALU_OPERATOR_MULHU), 5'(ALU_OPERATOR_DIV), 5'(ALU_OPERATOR_DIVU),
                  5'(ALU_OPERATOR_REM), 5'(ALU_OPERATOR_REMU), 5'd0, 5'd31};

        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_zero", result_is_zero, 1'b0);
        check("rst_illegal", out_illegal, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic and latency cases
        run_lat(5'(ALU_OPERATOR_MUL),   32'd7,          32'hFFFF_FFFD, XLEN);
        run_lat(5'(ALU_OPERATOR_MULHU), 32'hFFFF_FFFF,  32'hFFFF_FFFF, XLEN);
        run_lat(5'(ALU_OPERATOR_MULH),  32'hFFFF_FFFF,  32'hFFFF_FFFF, XLEN);
        run_lat(5'(ALU_OPERATOR_DIV),   32'hFFFF_FFF9,  32'd2,         XLEN);
        run_lat(5'(ALU_OPERATOR_REM),   32'hFFFF_FFF9,  32'd2,         XLEN);
        run_lat(5'(ALU_OPERATOR_DIVU),  32'd100,        32'd7,         XLEN);
        run_lat(5'(ALU_OPERATOR_REMU),  32'd100,        32'd7,         XLEN);
        run_lat(5'(ALU_OPERATOR_DIV),   32'd5,          32'd0,         1);
        run_lat(5'(ALU_OPERATOR_REMU),  32'd5,          32'd0,         1);
        run_lat(5'(ALU_OPERATOR_DIV),   32'h8000_0000,  32'hFFFF_FFFF, 1);
        run_lat(5'(ALU_OPERATOR_REM),   32'h8000_0000,  32'hFFFF_FFFF, 1);
        run_lat(5'd0,                   32'h1234_5678,  32'h9ABC_DEF0, 1);
        @(posedge clk); #1;

        // Backpressure: outputs held for five cycles, operands ignored, one handshake
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        ex = model(5'(ALU_OPERATOR_MULHU), 32'hDEAD_BEEF, 32'h1234_5678).res;
        issue(5'(ALU_OPERATOR_MULHU), 32'hDEAD_BEEF, 32'h1234_5678, ok);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("bp_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            operand1 = $urandom; operand2 = $urandom; operator = 5'(ALU_OPERATOR_MUL);
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_result", result, ex);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        ready_mode = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_single_handshake", out_valid, 1'b0);
        check("bp_scoreboard_empty", sb_q.size(), 0);

        // Flush during iteration 10
        issue(5'(ALU_OPERATOR_DIVU), 32'hFFFF_0000, 32'd3, ok);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_no_late_valid", seen, 1'b0);

        // Flush beats in_valid
        flush = 1'b1; in_valid = 1'b1;
        operator = 5'(ALU_OPERATOR_MUL); operand1 = 32'd3; operand2 = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_blocks_accept", in_ready, 1'b1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_accept_no_valid", seen, 1'b0);

        // Illegal op leaves illegal/zero set, then reset mid-CALC clears everything
        run_lat(5'd0, 32'd9, 32'd9, 1);
        @(posedge clk); #1;
        issue(5'(ALU_OPERATOR_MULHU), 32'hFFFF_FFFF, 32'h7777_7777, ok);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_result", result, 32'h0);
        check("midrst_zero", result_is_zero, 1'b0);
        check("midrst_illegal", out_illegal, 1'b0);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("midrst_no_stale_valid", seen, 1'b0);

        // Random operations with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            op = codes[$urandom_range(0, 9)];
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, ok);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        check("scoreboard_drain", sb_q.size(), 0);
        ready_mode = 1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
